// File: rtl/alu_muldiv_pkg.sv
// Shared multiply/divide constants: op codes, FSM state encodings, op-class helper.
// No logic, no latency, no flow control.
// Imported by alu_muldiv and md_div_core.
package alu_muldiv_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_md_div_core.sv
// Unsigned restoring shift-subtract divider datapath plus the shared iteration counter.
// One quotient bit per step; WIDTH steps after load.
// No backpressure: the owner drives load/step and reads quo/rem/cnt.
module md_div_core
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // rem < divisor always holds, so both the kept and the subtracted value fit in WIDTH bits
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo   <= '0;
            rem   <= '0;
            dvs_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            quo   <= dividend;
            rem   <= '0;
            dvs_q <= divisor;
            cnt   <= CNT_W'(WIDTH);
        end else if (step) begin
            quo <= {quo[WIDTH-2:0], ge};
            rem <= ge ? diff : shifted[WIDTH-1:0];
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: WIDTH+1 busy cycles (mul with MULDIV_FAST_MUL_EN, div-by-zero: 1); MTHI/MTLO: done next cycle.
// Backpressure: start ignored while busy or flushing; pipeline stalls on busy.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    md_state_e          state_q, state_d;
    logic               accept, op_ok, op_is_md, op_is_mul, op_signed, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_q, acc_init, prod;
    logic [WIDTH-1:0]   mcand_q;
    logic               sa_q, sb_q, is_mul_q, dz_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
    logic [CNT_W-1:0]   cnt;

    assign op_ok     = (op <= MD_MTLO);
    assign op_is_md  = (op <= MD_DIVU);
    assign op_is_mul = (op == MD_MULT) || (op == MD_MULTU);
    assign op_signed = md_is_signed(op);
    assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    assign div_zero  = !op_is_mul && (b == '0);
    assign accept    = (state_q == IDLE) && start && !flush && op_ok;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign acc_init = op_is_mul ? ({{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b})
                                : {{WIDTH{1'b0}}, mag_a};
`else
    localparam bit FAST_MUL = 1'b0;
    assign acc_init = {{WIDTH{1'b0}}, mag_a};
`endif

    md_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && op_is_md),
        .step     (state_q == CALC),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo      (quo),
        .rem      (rem),
        .cnt      (cnt)
    );

    // Shift-add multiply: upper half accumulates, multiplier drains out of the lower half
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && op_is_md) state_d = (op_is_mul ? FAST_MUL : div_zero) ? FIX : CALC;
            CALC: begin
                if (flush)                  state_d = IDLE;
                else if (cnt == CNT_W'(1))  state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (!is_mul_q) begin
            // quo still holds |a| when the divisor was zero, so the remainder sign rule yields hi = a
            fix_lo = dz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
            fix_hi = dz_q ? (sa_q ? -quo : quo) : (sa_q ? -rem : rem);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_mul_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= 1'b0;
            if (accept) begin
                if (op == MD_MTHI) begin
                    hi   <= a;
                    done <= 1'b1;
                end else if (op == MD_MTLO) begin
                    lo   <= a;
                    done <= 1'b1;
                end else begin
                    sa_q     <= op_signed && a[WIDTH-1];
                    sb_q     <= op_signed && b[WIDTH-1];
                    is_mul_q <= op_is_mul;
                    dz_q     <= div_zero;
                    acc_q    <= acc_init;
                    mcand_q  <= mag_b;
                end
            end
            if (state_q == CALC && is_mul_q) acc_q <= {sum, acc_q[WIDTH-1:1]};
            if (state_q == FIX && !flush) begin
                hi   <= fix_hi;
                lo   <= fix_lo;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed plus random checks of alu_muldiv against an arithmetic reference model.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// A hang trips the watchdog.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] hi_m, lo_m;
    int exp_busy;
    logic exp_done;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int busy_of(input logic [2:0] o, input logic [W-1:0] y);
        if (o == 3'd0 || o == 3'd1) return MUL_BUSY;
        if (o == 3'd2 || o == 3'd3) return (y == '0) ? 1 : W + 1;
        return 0;
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural values
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] p;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        exp_busy = busy_of(o, y);
        exp_done = (o <= 3'd5);
        case (o)
            3'd0: begin p = sx * sy; {hi_m, lo_m} = p; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; {hi_m, lo_m} = p; end
            3'd2: begin
                if (y == '0) begin hi_m = x; lo_m = '1; end
                else begin
                    p = sx / sy; lo_m = p[31:0];
                    p = sx % sy; hi_m = p[31:0];
                end
            end
            3'd3: begin
                if (y == '0) begin hi_m = x; lo_m = '1; end
                else begin lo_m = x / y; hi_m = x % y; end
            end
            3'd4: hi_m = x;
            3'd5: lo_m = x;
            default: ;
        endcase
    endtask

    // Issue at a falling edge; returns at the falling edge where busy is low again
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inject, input string tag);
        logic [W-1:0] old_hi, old_lo;
        int n;
        old_hi = hi_m;
        old_lo = lo_m;
        model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            check({tag, "/hold"}, {hi, lo}, {old_hi, old_lo});
            if (n == inject) begin
                start = 1'b1; op = MD_MTLO; a = $urandom;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "/busy_cycles"}, 64'(n), 64'(exp_busy));
        check({tag, "/done"}, 64'(done), 64'(exp_done));
        check({tag, "/hi"}, 64'(hi), 64'(hi_m));
        check({tag, "/lo"}, 64'(lo), 64'(lo_m));
    endtask

    task automatic idle_after(input string tag);
        @(negedge clk);
        check({tag, "/done_pulse_end"}, {62'b0, done, busy}, 64'b0);
    endtask

    task automatic run_flush(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int at, input string tag);
        int n;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < at) begin
            n++;
            @(negedge clk);
        end
        check({tag, "/busy_before_flush"}, {63'(n), busy}, {63'(at), 1'b1});
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check({tag, "/after_flush"}, {62'b0, busy, done}, 64'b0);
        check({tag, "/hilo_kept"}, {hi, lo}, {hi_m, lo_m});
        @(negedge clk);
        check({tag, "/no_late_done"}, 64'(done), 64'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {hi, lo}, 64'b0);
        check("reset_ctrl", {62'b0, busy, done}, 64'b0);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ro;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        @(negedge clk);
        do_reset();

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        idle_after("mult_neg");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        // back-to-back: next op issued in the done cycle
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIVU, 32'd7, 32'd2, 3, "divu_ign_mtlo");
        check("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);
        idle_after("divu");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(MD_DIVU, 32'd5, 32'd0, -1, "divu_zero");
        check("divu_zero_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        idle_after("divu_zero");

        do_reset();
        @(negedge clk);
        run_op(MD_MTHI, 32'h1234, 32'd0, -1, "mthi");
        check("mthi_const", {hi, lo}, 64'h0000_1234_0000_0000);
        idle_after("mthi");
        run_op(3'd6, 32'hDEAD_BEEF, 32'd1, -1, "reserved");

        start = 1'b1; op = MD_MTLO; a = 32'hCAFE_F00D; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", {31'b0, done, lo}, {31'b0, 1'b0, lo_m});

        run_flush(MD_MULT, 32'd1000, 32'd3, 10, "mult_flush");
        run_op(MD_DIVU, 32'd9, 32'd4, -1, "divu_after_flush");
        check("divu_after_flush_const", {hi, lo}, 64'h0000_0001_0000_0002);
        idle_after("divu_after_flush");

        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_mid_div", {30'b0, busy, done, hi}, 64'b0);
        check("async_reset_lo", 64'(lo), 64'b0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, -1, "mult_rerun");

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2: begin
                    ra = 32'($urandom_range(0, 40));
                    rb = 32'($urandom_range(1, 9));
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: ;
            endcase
            if (ro <= 3'd3 && $urandom_range(0, 4) == 0) begin
                run_flush(ro, ra, rb, $urandom_range(0, busy_of(ro, rb) - 1), "rand_flush");
            end else begin
                run_op(ro, ra, rb, (busy_of(ro, rb) > 8) ? 3 : -1, "rand");
                if ($urandom_range(0, 1) == 1) idle_after("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multiply/divide unit that extends the combinational ALU with multi-cycle MULT/MULTU/DIV/DIVU and the HI/LO register pair.
- Sits beside the ALU in the EX stage.
- Pipeline control stalls on busy and reads results from hi/lo (MFHI/MFLO).
- Uses a start/busy/done handshake, a synchronous flush for exceptions, and WIDTH-generic datapaths.

Parameters:
WIDTH, 32, operand/HI/LO width (even, >= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  3  MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; 6/7 reserved
a  input  WIDTH  operand A / dividend / MTHI-MTLO source
b  input  WIDTH  operand B / divisor
flush  input  1  synchronous abort of in-flight operation
busy  output  1  operation in flight; pipeline must stall MD ops and MFHI/MFLO
done  output  1  one-cycle pulse when hi/lo are updated
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (async, any time incl. mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- States: IDLE, CALC, FIX. busy=1 exactly in CALC and FIX. All outputs registered.
- Accept: start=1 and busy=0 and flush=0 at a rising edge. Otherwise start is ignored: while busy, on reserved op, or with flush.
- MTHI/MTLO: on accept, hi (resp. lo) <= a and done=1 next cycle. busy never rises; the other register is unchanged.
- MULT/MULTU/DIV/DIVU accept:
  - Latch |a|, |b| (signed ops) or raw a, b (unsigned), plus sign flags sa, sb.
  - counter <= WIDTH; go to CALC.
- CALC: one radix-2 iteration per cycle; counter decrements; at counter==1 go to FIX. WIDTH cycles in CALC total.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on unsigned magnitudes.
- FIX: apply signs, write hi/lo, go to IDLE, done=1 the following cycle.
  - Product negated if sa^sb (signed only).
  - Quotient negated if sa^sb; remainder takes the dividend's sign.
- Latency: busy high for WIDTH+1 cycles after the accept edge. hi/lo and done change on the edge that drops busy.
- Back-to-back: start may be accepted in the cycle done=1.
- Divide by zero: skip CALC and go straight to FIX (busy 1 cycle). lo = all ones, hi = a, regardless of signedness.
- Signed overflow (MIN / -1): lo = MIN, hi = 0. This falls out of the magnitude algorithm with no special case.
- Unsigned magnitude of MIN is 2^(WIDTH-1); no overflow inside the datapath.
- flush=1 at an edge:
  - Return to IDLE; hi/lo unchanged; no done.
  - Flush wins over start in the same cycle.
  - Flush in IDLE has no effect.
- hi/lo hold old values throughout busy; partial results are never visible.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU use one combinational signed/unsigned WIDTH x WIDTH multiply and go directly to FIX. busy is high 1 cycle; hi/lo and done follow on the next edge.
- Undefined: iterative multiply as above (WIDTH+1 busy cycles).
- Divide timing identical in both builds.

Decomposition:
- Shared constants header, alongside the ALU op codes:
  - MD_MULT..MD_MTLO op codes.
  - State encodings IDLE=0, CALC=1, FIX=2.
  - MD_OP_W=3.
- Natural sub-module md_div_core:
  - Unsigned restoring shift-subtract step with remainder/quotient registers and counter.
  - Ports clk/rst/load/step; parametrised by WIDTH.
  - Top level owns sign handling, the FSM, hi/lo and the multiply path.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=7 -> busy 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> busy exactly 1 cycle; hi=5, lo=0xFFFFFFFF, done pulse.
- MTHI a=0x1234 with hi=lo=0 -> next edge hi=0x1234, lo=0, done=1, busy never 1. start during busy with op=MTLO -> ignored, lo unchanged.
- Start MULT, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. Then start DIVU 9/4 is accepted -> lo=2, hi=1.
- Assert rst mid-DIV (cycle 5) -> immediately busy=0, done=0, hi=lo=0. With MULDIV_FAST_MUL_EN, rerun MULT -3*7 -> busy 1 cycle, same results.
